// File: rtl/ysyx_23060203_ifu_pkg.sv
// Shared types and constants for the decoupled fetch unit: opcodes,
// prediction modes, front-end state and the fetch-queue entry layout.
package ysyx_23060203_ifu_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum int {
    PRED_NONE     = 0,
    PRED_BTFN     = 1,
    PRED_BTFN_JAL = 2
  } pred_mode_e;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
  } fq_entry_t;

endpackage

// File: rtl/ysyx_23060203_fetch_queue.sv
// Circular buffer of fetched instructions; clear beats enq/deq, and the
// caller guarantees enq only when not full and deq only when not empty.
module ysyx_23060203_fetch_queue
  import ysyx_23060203_ifu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enq,
  input  entry_t                 enq_data,
  input  logic                   deq,
  output entry_t                 head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is reset (not just the pointers) because the head slot is
  // visible on the outputs and must read as zero straight out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enq && !clear) begin
      mem[tail] <= enq_data;
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/ysyx_23060203_ifu_fq.sv
// Instruction fetch unit: ICache lookup, static next-PC prediction and a
// fetch queue toward decode, with redirects from EXU and CSR.
module ysyx_23060203_ifu_fq
  import ysyx_23060203_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int          DEPTH     = 4,
  parameter int          PRED_MODE = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   jump_flush,
  input  logic [31:0]            jump_dnpc,
  input  logic                   cs_flush,
  input  logic [31:0]            cs_dnpc,
  output logic [31:0]            fetch_addr,
  input  logic                   fetch_hit,
  input  logic [31:0]            fetch_inst,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic                   out_pred_taken,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t      state, state_next;
  logic [31:0] redirect, redirect_next;
  logic [31:0] fetch_addr_next;
  logic        flush;
  logic [31:0] dnpc;
  logic        enq;
  logic        deq;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] incr;
  logic        taken;
  fq_entry_t   enq_entry;
  fq_entry_t   head_entry;

  assign flush = cs_flush | jump_flush;
  assign dnpc  = cs_flush ? cs_dnpc : jump_dnpc;

  assign imm_b = {{19{fetch_inst[31]}}, fetch_inst[31], fetch_inst[7],
                  fetch_inst[30:25], fetch_inst[11:8], 1'b0};
  assign imm_j = {{11{fetch_inst[31]}}, fetch_inst[31], fetch_inst[19:12],
                  fetch_inst[20], fetch_inst[30:21], 1'b0};

  // Backward branches are predicted taken; JAL only in the richest mode.
  always_comb begin
    incr = 32'd4;
    if (PRED_MODE >= int'(PRED_BTFN) && fetch_inst[6:2] == OP_BRANCH && fetch_inst[31])
      incr = imm_b;
    else if (PRED_MODE == int'(PRED_BTFN_JAL) && fetch_inst[6:2] == OP_JAL)
      incr = imm_j;
  end

  assign taken     = (incr != 32'd4);
  assign enq_entry = '{pc: fetch_addr, inst: fetch_inst, taken: taken};

  assign enq       = (state == RUN) && fetch_hit && !flush && (q_count < FULL);
  assign out_valid = (q_count != '0) && !flush;
  assign deq       = out_valid && out_ready;

  ysyx_23060203_fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (fq_entry_t)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .enq       (enq),
    .enq_data  (enq_entry),
    .deq       (deq),
    .head_data (head_entry),
    .count     (q_count)
  );

  assign out_pc         = head_entry.pc;
  assign out_inst       = head_entry.inst;
  assign out_pred_taken = head_entry.taken;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    redirect_next   = redirect;
    fetch_addr_next = fetch_addr;
    case (state)
      RUN: begin
        if (flush) begin
          if (fetch_hit) begin
            fetch_addr_next = dnpc;
          end else begin
            // A refill is in flight on fetch_addr; park the target instead.
            redirect_next = dnpc;
            state_next    = REDIRECT;
          end
        end else if (enq) begin
          fetch_addr_next = fetch_addr + incr;
        end
      end
      REDIRECT: begin
        if (fetch_hit) begin
          fetch_addr_next = flush ? dnpc : redirect;
          state_next      = RUN;
        end else if (flush) begin
          redirect_next = dnpc;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      redirect   <= '0;
      fetch_addr <= RESET_PC;
    end else begin
      state      <= state_next;
      redirect   <= redirect_next;
      fetch_addr <= fetch_addr_next;
    end
  end

`ifndef SYNTHESIS
  PERF_IFU_INST:  cover property (@(posedge clock) deq);
  PERF_IFU_FULL:  cover property (@(posedge clock) q_count == FULL);
  PERF_IFU_WAIT:  cover property (@(posedge clock) !fetch_hit);
  PERF_IFU_REDIR: cover property (@(posedge clock) state == REDIRECT);
`endif

endmodule

// File: tb/tb_ysyx_23060203_ifu_fq.sv
// Directed bench for the fetch unit; three instances share stimulus so the
// prediction modes can be compared side by side.
module tb_ysyx_23060203_ifu_fq;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'hFE00_0EE3;  // beq x0,x0,-4
  localparam logic [31:0] JAL  = 32'h0100_006F;  // jal x0,+16

  logic        clock = 1'b0;
  logic        reset;
  logic        jump_flush, cs_flush;
  logic [31:0] jump_dnpc, cs_dnpc;
  logic        fetch_hit;
  logic [31:0] fetch_inst;
  logic        out_ready;

  logic [31:0] fa1, fa0, fa2;
  logic        ov1, ov0, ov2;
  logic [31:0] pc1, pc0, pc2;
  logic [31:0] in1, in0, in2;
  logic        tk1, tk0, tk2;
  logic [2:0]  qc1, qc0, qc2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_23060203_ifu_fq #(.PRED_MODE(1)) u_dut (
    .clock(clock), .reset(reset),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
    .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .fetch_addr(fa1), .fetch_hit(fetch_hit), .fetch_inst(fetch_inst),
    .out_ready(out_ready), .out_valid(ov1), .out_pc(pc1), .out_inst(in1),
    .out_pred_taken(tk1), .q_count(qc1)
  );

  ysyx_23060203_ifu_fq #(.PRED_MODE(0)) u_m0 (
    .clock(clock), .reset(reset),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
    .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .fetch_addr(fa0), .fetch_hit(fetch_hit), .fetch_inst(fetch_inst),
    .out_ready(out_ready), .out_valid(ov0), .out_pc(pc0), .out_inst(in0),
    .out_pred_taken(tk0), .q_count(qc0)
  );

  ysyx_23060203_ifu_fq #(.PRED_MODE(2)) u_m2 (
    .clock(clock), .reset(reset),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
    .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .fetch_addr(fa2), .fetch_hit(fetch_hit), .fetch_inst(fetch_inst),
    .out_ready(out_ready), .out_valid(ov2), .out_pc(pc2), .out_inst(in2),
    .out_pred_taken(tk2), .q_count(qc2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    fetch_hit  = 1'b0;
    fetch_inst = NOP;
    out_ready  = 1'b0;
    jump_flush = 1'b0;
    cs_flush   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    jump_dnpc = '0;
    cs_dnpc   = '0;

    // Reset state and one-per-cycle streaming.
    do_reset();
    #1;
    check("rst_fetch_addr", fa1, 32'h8000_0000);
    check("rst_q_count", {29'd0, qc1}, 32'd0);
    check("rst_out_valid", {31'd0, ov1}, 32'd0);
    check("rst_out_pc", pc1, 32'd0);
    check("rst_out_inst", in1, 32'd0);
    check("rst_out_taken", {31'd0, tk1}, 32'd0);

    fetch_hit = 1'b1;
    out_ready = 1'b1;
    tick();
    check("stream0_valid", {31'd0, ov1}, 32'd1);
    check("stream0_pc", pc1, 32'h8000_0000);
    tick();
    check("stream1_pc", pc1, 32'h8000_0004);
    check("stream1_count", {29'd0, qc1}, 32'd1);
    tick();
    check("stream2_pc", pc1, 32'h8000_0008);

    // Fill the queue with decode stalled.
    do_reset();
    fetch_hit = 1'b1;
    repeat (4) tick();
    check("full_count", {29'd0, qc1}, 32'd4);
    check("full_fetch_addr", fa1, 32'h8000_0010);
    tick();
    check("full_hold_count", {29'd0, qc1}, 32'd4);
    check("full_hold_addr", fa1, 32'h8000_0010);
    check("full_head_pc", pc1, 32'h8000_0000);
    out_ready = 1'b1;
    #1;
    check("full_deq_valid", {31'd0, ov1}, 32'd1);
    tick();
    out_ready = 1'b0;
    check("deq_no_enq_count", {29'd0, qc1}, 32'd3);
    check("deq_no_enq_addr", fa1, 32'h8000_0010);
    check("deq_head_pc", pc1, 32'h8000_0004);
    tick();
    check("refill_count", {29'd0, qc1}, 32'd4);
    check("refill_addr", fa1, 32'h8000_0014);

    // Flush of a full queue while the lookup hits.
    jump_flush = 1'b1;
    jump_dnpc  = 32'h8000_0100;
    out_ready  = 1'b1;
    #1;
    check("flush_squash_valid", {31'd0, ov1}, 32'd0);
    tick();
    check("flush_count", {29'd0, qc1}, 32'd0);
    check("flush_addr", fa1, 32'h8000_0100);

    // Flush during a miss parks the target; a later cs_flush replaces it.
    fetch_hit = 1'b0;
    jump_dnpc = 32'h8000_0200;
    tick();
    jump_flush = 1'b0;
    check("redir_hold0", fa1, 32'h8000_0100);
    tick();
    check("redir_hold1", fa1, 32'h8000_0100);
    cs_flush = 1'b1;
    cs_dnpc  = 32'h8000_0300;
    tick();
    cs_flush = 1'b0;
    check("redir_hold2", fa1, 32'h8000_0100);
    fetch_hit = 1'b1;
    #1;
    check("redir_valid", {31'd0, ov1}, 32'd0);
    tick();
    check("redir_target", fa1, 32'h8000_0300);
    check("redir_discard", {29'd0, qc1}, 32'd0);
    tick();
    check("redir_first_count", {29'd0, qc1}, 32'd1);
    check("redir_first_pc", pc1, 32'h8000_0300);
    check("redir_next_addr", fa1, 32'h8000_0304);

    // Simultaneous redirects: CSR wins.
    jump_flush = 1'b1;
    jump_dnpc  = 32'h8000_0400;
    cs_flush   = 1'b1;
    cs_dnpc    = 32'h8000_0500;
    tick();
    jump_flush = 1'b0;
    cs_flush   = 1'b0;
    check("prio_addr", fa1, 32'h8000_0500);
    check("prio_count", {29'd0, qc1}, 32'd0);

    // Reset while parked in REDIRECT, then branch/JAL prediction per mode.
    fetch_hit  = 1'b0;
    jump_flush = 1'b1;
    jump_dnpc  = 32'h8000_0600;
    tick();
    jump_flush = 1'b0;
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    fetch_hit = 1'b1;
    out_ready = 1'b1;
    fetch_inst = NOP;
    check("rst_redir_addr", fa1, 32'h8000_0000);
    tick();
    check("rst_redir_run", {29'd0, qc1}, 32'd1);
    tick();
    check("pre_branch_addr", fa1, 32'h8000_0008);
    fetch_inst = BEQ;
    tick();
    fetch_inst = JAL;
    check("m1_branch_next", fa1, 32'h8000_0004);
    check("m1_branch_pc", pc1, 32'h8000_0008);
    check("m1_branch_inst", in1, BEQ);
    check("m1_branch_taken", {31'd0, tk1}, 32'd1);
    check("m0_branch_next", fa0, 32'h8000_000C);
    check("m0_branch_taken", {31'd0, tk0}, 32'd0);
    check("m2_branch_next", fa2, 32'h8000_0004);
    tick();
    fetch_inst = NOP;
    check("m2_jal_next", fa2, 32'h8000_0014);
    check("m2_jal_taken", {31'd0, tk2}, 32'd1);
    check("m1_jal_next", fa1, 32'h8000_0008);
    check("m1_jal_taken", {31'd0, tk1}, 32'd0);
    check("m0_jal_next", fa0, 32'h8000_0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
